// File: rtl/mem_pkg.sv
// Shared types and constants for the instruction/data SRAM arbiter.
package mem_pkg;

  typedef enum logic [1:0] {IDLE, BUSY_IFU, BUSY_LSU} arb_state_t;

  localparam logic MID_IFU = 1'b0;
  localparam logic MID_LSU = 1'b1;

  localparam int unsigned DEF_ADDR_W = 32;
  localparam int unsigned DEF_DATA_W = 32;

endpackage

// File: rtl/arb_watchdog.sv
// Busy-cycle watchdog: counts stalled cycles of one access and flags the abort point.
// TIMEOUT = 0 disables the abort entirely.
module arb_watchdog #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic timeout_c
);

  localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt;
  logic             at_limit_c;

  assign at_limit_c = (cnt == CNT_W'(TIMEOUT));
  assign timeout_c  = (TIMEOUT != 0) && at_limit_c;

  // Saturates at the limit so a disabled watchdog never wraps.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en && !at_limit_c) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master (ifu, lsu) arbiter for the shared instruction/data SRAM port.
// Define MEM_ARB_RR_EN for round-robin tie-breaking; default is fixed lsu priority.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ifu_req,
  input  logic [ADDR_W-1:0]     ifu_addr,
  output logic                  ifu_rvalid,
  output logic [DATA_W-1:0]     ifu_rdata,
  output logic                  ifu_err,
  input  logic                  lsu_req,
  input  logic [ADDR_W-1:0]     lsu_addr,
  input  logic                  lsu_wen,
  input  logic [DATA_W-1:0]     lsu_wdata,
  input  logic [DATA_W/8-1:0]   lsu_wmask,
  output logic                  lsu_rvalid,
  output logic [DATA_W-1:0]     lsu_rdata,
  output logic                  lsu_err,
  output logic                  s_req,
  output logic [ADDR_W-1:0]     s_addr,
  output logic                  s_wen,
  output logic [DATA_W-1:0]     s_wdata,
  output logic [DATA_W/8-1:0]   s_wmask,
  input  logic                  s_ready,
  input  logic [DATA_W-1:0]     s_rdata
);

  arb_state_t        state;
  logic              any_req_c;
  logic              grant_lsu_c;
  logic              busy_c;
  logic              timeout_c;
  logic              done_c;
  logic [DATA_W-1:0] resp_data_c;

  assign any_req_c   = ifu_req || lsu_req;
  assign busy_c      = (state != IDLE);
  // A reset in the completion cycle suppresses the response.
  assign done_c      = busy_c && !rst && (s_ready || timeout_c);
  assign resp_data_c = (s_ready && !s_wen) ? s_rdata : '0;

`ifdef MEM_ARB_RR_EN
  logic last_grant;

  assign grant_lsu_c = lsu_req && (!ifu_req || (last_grant == MID_IFU));

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= MID_IFU;
    end else if ((state == IDLE) && any_req_c) begin
      last_grant <= grant_lsu_c ? MID_LSU : MID_IFU;
    end
  end
`else
  assign grant_lsu_c = lsu_req;
`endif

  arb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk       (clk),
    .rst       (rst),
    .clr       (!busy_c),
    .en        (busy_c && !s_ready),
    .timeout_c (timeout_c)
  );

  // Grant, latch the winner's request and sequence the slave access.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      s_req   <= 1'b0;
      s_addr  <= '0;
      s_wen   <= 1'b0;
      s_wdata <= '0;
      s_wmask <= '0;
    end else begin
      s_req <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req_c) begin
            s_req <= 1'b1;
            if (grant_lsu_c) begin
              state   <= BUSY_LSU;
              s_addr  <= lsu_addr;
              s_wen   <= lsu_wen;
              s_wdata <= lsu_wdata;
              s_wmask <= lsu_wmask;
            end else begin
              state   <= BUSY_IFU;
              s_addr  <= ifu_addr;
              s_wen   <= 1'b0;
              s_wdata <= '0;
              s_wmask <= '0;
            end
          end
        end
        BUSY_IFU, BUSY_LSU: begin
          if (s_ready || timeout_c) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Route the completion (normal or aborted) to the granted master only.
  always_comb begin
    ifu_rvalid = 1'b0;
    ifu_err    = 1'b0;
    ifu_rdata  = '0;
    lsu_rvalid = 1'b0;
    lsu_err    = 1'b0;
    lsu_rdata  = '0;
    if (done_c && (state == BUSY_IFU)) begin
      ifu_rvalid = 1'b1;
      ifu_err    = !s_ready;
      ifu_rdata  = resp_data_c;
    end
    if (done_c && (state == BUSY_LSU)) begin
      lsu_rvalid = 1'b1;
      lsu_err    = !s_ready;
      lsu_rdata  = resp_data_c;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_mem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned MW = 4;
  localparam int unsigned TO = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          ifu_req;
  logic [AW-1:0] ifu_addr;
  logic          ifu_rvalid;
  logic [DW-1:0] ifu_rdata;
  logic          ifu_err;
  logic          lsu_req;
  logic [AW-1:0] lsu_addr;
  logic          lsu_wen;
  logic [DW-1:0] lsu_wdata;
  logic [MW-1:0] lsu_wmask;
  logic          lsu_rvalid;
  logic [DW-1:0] lsu_rdata;
  logic          lsu_err;
  logic          s_req;
  logic [AW-1:0] s_addr;
  logic          s_wen;
  logic [DW-1:0] s_wdata;
  logic [MW-1:0] s_wmask;
  logic          s_ready;
  logic [DW-1:0] s_rdata;

  always #5 clk = ~clk;

  mem_arbiter #(
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .TIMEOUT (TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ifu_req    (ifu_req),
    .ifu_addr   (ifu_addr),
    .ifu_rvalid (ifu_rvalid),
    .ifu_rdata  (ifu_rdata),
    .ifu_err    (ifu_err),
    .lsu_req    (lsu_req),
    .lsu_addr   (lsu_addr),
    .lsu_wen    (lsu_wen),
    .lsu_wdata  (lsu_wdata),
    .lsu_wmask  (lsu_wmask),
    .lsu_rvalid (lsu_rvalid),
    .lsu_rdata  (lsu_rdata),
    .lsu_err    (lsu_err),
    .s_req      (s_req),
    .s_addr     (s_addr),
    .s_wen      (s_wen),
    .s_wdata    (s_wdata),
    .s_wmask    (s_wmask),
    .s_ready    (s_ready),
    .s_rdata    (s_rdata)
  );

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Transaction model: who owns the slave, what was captured, how long it has been outstanding.
  int            owner = 0;  // 0 none, 1 ifu, 2 lsu
  int            age   = 0;  // busy cycles already spent on the current access
  logic [AW-1:0] m_addr  = '0;
  logic          m_wen   = 1'b0;
  logic [DW-1:0] m_wdata = '0;
  logic [MW-1:0] m_wmask = '0;
`ifdef MEM_ARB_RR_EN
  int            rr_last = 1;
`endif

  function automatic bit m_done();
    return (owner != 0) && !rst && (s_ready || ((TO != 0) && (age == int'(TO))));
  endfunction

  function automatic bit m_pick_lsu();
    if (!lsu_req) return 1'b0;
    if (!ifu_req) return 1'b1;
`ifdef MEM_ARB_RR_EN
    return rr_last == 1;
`else
    return 1'b1;
`endif
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      owner = 0;
      age   = 0;
`ifdef MEM_ARB_RR_EN
      rr_last = 1;
`endif
    end else if (owner == 0) begin
      if (ifu_req || lsu_req) begin
        if (m_pick_lsu()) begin
          owner = 2; m_addr = lsu_addr; m_wen = lsu_wen; m_wdata = lsu_wdata; m_wmask = lsu_wmask;
        end else begin
          owner = 1; m_addr = ifu_addr; m_wen = 1'b0; m_wdata = '0; m_wmask = '0;
        end
        age = 0;
`ifdef MEM_ARB_RR_EN
        rr_last = owner;
`endif
      end
    end else if (m_done()) begin
      owner = 0;
    end else begin
      age++;
    end
  end

  // Compare every cycle against the model.
  always @(negedge clk) begin
    bit            d;
    bit            e;
    logic [DW-1:0] rd;
    d  = m_done();
    e  = d && !s_ready;
    rd = (d && s_ready && !m_wen) ? s_rdata : '0;
    check("m_s_req", 64'(s_req), 64'((owner != 0) && (age == 0)));
    if (owner != 0) begin
      check("m_s_addr", 64'(s_addr), 64'(m_addr));
      check("m_s_wen", 64'(s_wen), 64'(m_wen));
      check("m_s_wmask", 64'(s_wmask), 64'(m_wmask));
      if (m_wen) check("m_s_wdata", 64'(s_wdata), 64'(m_wdata));
    end
    check("m_ifu_rvalid", 64'(ifu_rvalid), 64'(d && (owner == 1)));
    check("m_ifu_err", 64'(ifu_err), 64'(e && (owner == 1)));
    if ((owner != 1) || d) check("m_ifu_rdata", 64'(ifu_rdata), 64'((owner == 1) ? rd : '0));
    check("m_lsu_rvalid", 64'(lsu_rvalid), 64'(d && (owner == 2)));
    check("m_lsu_err", 64'(lsu_err), 64'(e && (owner == 2)));
    if ((owner != 2) || d) check("m_lsu_rdata", 64'(lsu_rdata), 64'((owner == 2) ? rd : '0));
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_s_req"}, 64'(s_req), 64'(0));
    check({tag, "_s_addr"}, 64'(s_addr), 64'(0));
    check({tag, "_s_wen"}, 64'(s_wen), 64'(0));
    check({tag, "_s_wdata"}, 64'(s_wdata), 64'(0));
    check({tag, "_s_wmask"}, 64'(s_wmask), 64'(0));
    check({tag, "_ifu_rvalid"}, 64'(ifu_rvalid), 64'(0));
    check({tag, "_lsu_rvalid"}, 64'(lsu_rvalid), 64'(0));
    check({tag, "_ifu_err"}, 64'(ifu_err), 64'(0));
    check({tag, "_lsu_err"}, 64'(lsu_err), 64'(0));
    check({tag, "_ifu_rdata"}, 64'(ifu_rdata), 64'(0));
    check({tag, "_lsu_rdata"}, 64'(lsu_rdata), 64'(0));
  endtask

  initial begin
    int seen[$];
    int exp_seq[4];
    int thr;
    bit ifu_seen;
    bit lsu_seen;

    rst = 1'b1; ifu_req = 1'b0; ifu_addr = '0;
    lsu_req = 1'b0; lsu_addr = '0; lsu_wen = 1'b0; lsu_wdata = '0; lsu_wmask = '0;
    s_ready = 1'b0; s_rdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_all_zero("reset");

    // Tie in IDLE: lsu first, ifu address held off the bus until lsu completes.
    cyc(); ifu_req = 1'b1; ifu_addr = 32'h0000_0100; lsu_req = 1'b1; lsu_addr = 32'h0000_0200; lsu_wen = 1'b0;
    @(negedge clk); check("tie_idle_s_req", 64'(s_req), 64'(0));
    cyc(); s_ready = 1'b1; s_rdata = 32'hAAAA_0001;
    @(negedge clk);
    check("tie_lsu_s_addr", 64'(s_addr), 64'h200);
    check("tie_lsu_rvalid", 64'(lsu_rvalid), 64'(1));
    check("tie_lsu_rdata", 64'(lsu_rdata), 64'hAAAA_0001);
    check("tie_ifu_rvalid_0", 64'(ifu_rvalid), 64'(0));
    cyc(); lsu_req = 1'b0; s_ready = 1'b0;
    @(negedge clk);
    check("tie_gap_s_req", 64'(s_req), 64'(0));
    check("tie_gap_s_addr", 64'(s_addr), 64'h200);
    cyc(); s_ready = 1'b1; s_rdata = 32'hBBBB_0002;
    @(negedge clk);
    check("tie_ifu_s_addr", 64'(s_addr), 64'h100);
    check("tie_ifu_rvalid", 64'(ifu_rvalid), 64'(1));
    check("tie_ifu_rdata", 64'(ifu_rdata), 64'hBBBB_0002);
    cyc(); ifu_req = 1'b0; s_ready = 1'b0;

    // Single fetch, slave ready two cycles after the request pulse.
    cyc(); ifu_req = 1'b1; ifu_addr = 32'h8000_0000;
    @(negedge clk); check("fetch_idle_s_req", 64'(s_req), 64'(0));
    cyc(); @(negedge clk);
    check("fetch_s_req", 64'(s_req), 64'(1));
    check("fetch_s_addr", 64'(s_addr), 64'h8000_0000);
    check("fetch_s_wen", 64'(s_wen), 64'(0));
    check("fetch_s_wmask", 64'(s_wmask), 64'(0));
    cyc(); @(negedge clk);
    check("fetch_wait_s_req", 64'(s_req), 64'(0));
    check("fetch_wait_rvalid", 64'(ifu_rvalid), 64'(0));
    cyc(); s_ready = 1'b1; s_rdata = 32'h0010_0073;
    @(negedge clk);
    check("fetch_rvalid", 64'(ifu_rvalid), 64'(1));
    check("fetch_rdata", 64'(ifu_rdata), 64'h0010_0073);
    check("fetch_err", 64'(ifu_err), 64'(0));
    check("fetch_done_s_req", 64'(s_req), 64'(0));
    cyc(); ifu_req = 1'b0; s_ready = 1'b0;
    @(negedge clk); check("fetch_after_rvalid", 64'(ifu_rvalid), 64'(0));

    // Store, slave ready the cycle after the request pulse.
    cyc(); lsu_req = 1'b1; lsu_wen = 1'b1; lsu_addr = 32'h8000_1000; lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'hF;
    cyc(); @(negedge clk);
    check("store_s_req", 64'(s_req), 64'(1));
    check("store_s_wen", 64'(s_wen), 64'(1));
    check("store_s_wdata", 64'(s_wdata), 64'hDEAD_BEEF);
    check("store_s_wmask", 64'(s_wmask), 64'hF);
    cyc(); s_ready = 1'b1; s_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    check("store_rvalid", 64'(lsu_rvalid), 64'(1));
    check("store_rdata", 64'(lsu_rdata), 64'(0));
    check("store_held_wdata", 64'(s_wdata), 64'hDEAD_BEEF);
    cyc(); lsu_req = 1'b0; lsu_wen = 1'b0; s_ready = 1'b0;

    // Watchdog abort after TO stalled cycles, then a normal access.
    cyc(); lsu_req = 1'b1; lsu_addr = 32'h0000_0300; s_rdata = 32'h5555_AAAA;
    for (int k = 0; k < 4; k++) begin
      cyc(); @(negedge clk);
      check("to_wait_rvalid", 64'(lsu_rvalid), 64'(0));
    end
    cyc(); @(negedge clk);
    check("to_rvalid", 64'(lsu_rvalid), 64'(1));
    check("to_err", 64'(lsu_err), 64'(1));
    check("to_rdata", 64'(lsu_rdata), 64'(0));
    cyc(); lsu_req = 1'b0; ifu_req = 1'b1; ifu_addr = 32'h0000_0400;
    cyc(); s_ready = 1'b1; s_rdata = 32'h1122_3344;
    @(negedge clk);
    check("to_next_s_addr", 64'(s_addr), 64'h400);
    check("to_next_rvalid", 64'(ifu_rvalid), 64'(1));
    check("to_next_err", 64'(ifu_err), 64'(0));
    check("to_next_rdata", 64'(ifu_rdata), 64'h1122_3344);
    cyc(); ifu_req = 1'b0; s_ready = 1'b0;

    // Reset mid-access with s_ready in the reset cycle.
    cyc(); ifu_req = 1'b1; ifu_addr = 32'h0000_0500;
    cyc(); @(negedge clk); check("rst_busy_s_req", 64'(s_req), 64'(1));
    cyc(); rst = 1'b1; s_ready = 1'b1; s_rdata = 32'h0000_0099;
    @(negedge clk); check("rst_no_rvalid", 64'(ifu_rvalid), 64'(0));
    cyc(); rst = 1'b0; ifu_req = 1'b0; s_ready = 1'b0;
    @(negedge clk);
    check_all_zero("rst_after");

    // Both masters requesting continuously: record grant order.
    cyc(); ifu_req = 1'b1; ifu_addr = 32'h0000_0600; lsu_req = 1'b1; lsu_addr = 32'h0000_0700; lsu_wen = 1'b0;
    s_ready = 1'b1; s_rdata = 32'h0BAD_F00D;
    for (int k = 0; k < 20 && seen.size() < 4; k++) begin
      @(negedge clk);
      if (s_req) seen.push_back((s_addr == 32'h0000_0700) ? 2 : 1);
      cyc();
    end
`ifdef MEM_ARB_RR_EN
    exp_seq = '{2, 1, 2, 1};
`else
    exp_seq = '{2, 2, 2, 2};
`endif
    check("grant_count", 64'(seen.size()), 64'(4));
    for (int k = 0; k < seen.size() && k < 4; k++) check("grant_order", 64'(seen[k]), 64'(exp_seq[k]));
    ifu_req = 1'b0; lsu_req = 1'b0;
    cyc(); s_ready = 1'b0;
    repeat (8) cyc();

    // Random traffic; masters hold requests until their response, slave stalls vary by phase.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      ifu_seen = ifu_rvalid;
      lsu_seen = lsu_rvalid;
      cyc();
      if (ifu_req && ifu_seen) ifu_req = 1'b0;
      else if (!ifu_req && $urandom_range(0, 2) == 0) begin
        ifu_req = 1'b1; ifu_addr = $urandom;
      end
      if (lsu_req && lsu_seen) lsu_req = 1'b0;
      else if (!lsu_req && $urandom_range(0, 2) == 0) begin
        lsu_req = 1'b1; lsu_addr = $urandom; lsu_wen = 1'($urandom_range(0, 1));
        lsu_wdata = $urandom; lsu_wmask = 4'($urandom);
      end
      case ((i / 500) % 4)
        0:       thr = 5;
        1:       thr = 1;
        2:       thr = 9;
        default: thr = 0;
      endcase
      s_ready = (int'($urandom_range(0, 9)) < thr);
      s_rdata = $urandom;
      rst     = ($urandom_range(0, 79) == 0);
    end
    rst = 1'b0; ifu_req = 1'b0; lsu_req = 1'b0; s_ready = 1'b0;
    repeat (10) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-master, one-slave arbiter that shares the single instruction/data SRAM port between the fetch unit (master 0, "ifu") and the load/store unit (master 1, "lsu").
- Sequences each access as one slave request pulse followed by a wait for the slave ready.
- Returns the response only to the granted master.
- Includes a watchdog that aborts accesses the slave never completes.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; the write mask is DATA_W/8 bits.
- TIMEOUT, 255, maximum number of BUSY cycles before abort; 0 disables the watchdog.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ifu_req  in  1  fetch request; level, held until ifu_rvalid
- ifu_addr  in  ADDR_W  fetch address
- ifu_rvalid  out  1  fetch response valid (one cycle)
- ifu_rdata  out  DATA_W  fetch data
- ifu_err  out  1  fetch aborted by timeout (qualifies ifu_rvalid)
- lsu_req  in  1  load/store request; level, held until lsu_rvalid
- lsu_addr  in  ADDR_W  load/store address
- lsu_wen  in  1  1 = store
- lsu_wdata  in  DATA_W  store data
- lsu_wmask  in  DATA_W/8  byte enables
- lsu_rvalid  out  1  load/store response valid (one cycle)
- lsu_rdata  out  DATA_W  load data (0 for stores)
- lsu_err  out  1  load/store aborted by timeout
- s_req  out  1  slave request pulse
- s_addr  out  ADDR_W  latched address
- s_wen  out  1  latched write enable
- s_wdata  out  DATA_W  latched write data
- s_wmask  out  DATA_W/8  latched write mask
- s_ready  in  1  slave response valid
- s_rdata  in  DATA_W  slave read data

Behaviour:
- States: IDLE, BUSY_IFU, BUSY_LSU. Reset state is IDLE.
- Reset values: all outputs 0, latched address/data/mask 0, watchdog counter 0.
- IDLE arbitration (default): fixed priority, lsu over ifu.
  - Winner's request fields are latched at the edge.
  - State moves to BUSY_x.
  - s_req=1 for exactly the first BUSY cycle.
  - A fetch grant forces s_wen=0 and s_wmask=0.
- No request in IDLE: stay in IDLE, s_req=0.
- BUSY_x: s_addr/s_wen/s_wdata/s_wmask hold the latched values for the whole state. Master inputs are ignored.
- s_ready is sampled only in BUSY states, including the s_req cycle; s_ready in IDLE is ignored.
- Completion: s_ready=1 in BUSY_x gives, in that same cycle:
  - x_rvalid=1;
  - x_rdata=s_rdata, pass-through, forced to 0 when s_wen=1;
  - x_err=0.
  - Next state is IDLE.
- Latency: request seen in IDLE cycle N → s_req in cycle N+1 → earliest rvalid in cycle N+1. Minimum master-to-master turnaround is 2 cycles, since IDLE is always visited between grants.
- Non-granted master: rvalid=0, rdata=0, err=0. Its request waits and is never dropped.
- Watchdog:
  - Counter clears on entry to BUSY and increments each BUSY cycle without s_ready.
  - When count==TIMEOUT and s_ready=0: x_rvalid=1, x_err=1, x_rdata=0, then IDLE.
  - If s_ready and timeout coincide, normal completion wins.
- Simultaneous ifu_req and lsu_req in IDLE: lsu is granted; ifu is granted in the next IDLE unless lsu requests again (starvation is possible by default).
- Reset mid-access: return to IDLE immediately with no rvalid. The master re-requests after reset.
- Requester drops req while BUSY: this is a protocol violation. The access still completes, and rvalid is still pulsed.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: round-robin arbitration.
  - A last-grant flop (reset value = ifu, so lsu wins the first tie) updates on each grant.
  - On a tie, the master not granted last wins.
  - A single requester always wins.
- Undefined: fixed lsu priority, with no last-grant flop.

Decomposition:
- Shared package mem_pkg holds:
  - state encoding typedef arb_state_t {IDLE, BUSY_IFU, BUSY_LSU};
  - master ID constants MID_IFU=0, MID_LSU=1;
  - the default ADDR_W/DATA_W constants.
- One natural sub-module, arb_watchdog: counter, clear/enable inputs, and a timeout output, parameterised by TIMEOUT.

Test Plan:
- Single fetch: ifu_req=1, addr=0x80000000, slave s_ready 2 cycles after s_req with rdata=0x00100073 → exactly one s_req pulse with s_addr=0x80000000, then ifu_rvalid=1 with ifu_rdata=0x00100073 in the s_ready cycle, then IDLE.
- Store: lsu_req=1, wen=1, addr=0x80001000, wdata=0xDEADBEEF, wmask=0xF, s_ready next cycle → s_wen=1 with s_wdata=0xDEADBEEF held; lsu_rvalid=1, lsu_rdata=0.
- Tie: ifu_req and lsu_req both high in the same IDLE cycle → lsu serviced first, ifu serviced second; the ifu address does not appear on s_addr until the lsu completes.
- Timeout with TIMEOUT=4 and s_ready held 0 → abort after 4 BUSY cycles: lsu_rvalid=1, lsu_err=1, lsu_rdata=0; the next request proceeds normally.
- rst asserted mid-BUSY_IFU, with s_ready arriving in the rst cycle → no ifu_rvalid; state is IDLE and all outputs are 0 the next cycle.
- With MEM_ARB_RR_EN, both masters requesting continuously → grants alternate lsu, ifu, lsu, ifu.
